m_switch_allocator: RTL and testbench
=====================================

// Module: m_switch_allocator
// PURPOSE
//  Wormhole switch allocator for the 5-port router. Sits directly upstream of the crossbar data switch.
//  Per output port: picks one input by round-robin and locks it for the whole packet.
//  Drives the one-hot crossbar selects sel_0..sel_4 and pops the winning input buffers via in_grant.
//  Ports: 0=local, 1=N, 2=E, 3=S, 4=W.
// PARAMETERS
//  P_NUM_PORTS  5  router radix; fixed at 5, must match the crossbar
//  P_DST_WIDTH  3  width of each routed destination-port field
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   5   bit i: input buffer i has a flit at its head
//  req_head     in   5   bit i: that flit is a head flit
//  req_tail     in   5   bit i: that flit is a tail flit (head&tail = single-flit packet)
//  req_dst      in   15  [3i+2:3i] = output port from route compute for input i; sampled on head only
//  out_ready    in   5   bit k: output k / downstream can take a flit this cycle (credit available)
//  sel_0..sel_4 out  5   one-hot input select per output k; 0 = idle (crossbar emits const 0)
//  out_valid    out  5   bit k = |sel_k
//  in_grant     out  5   bit i: input i's flit transfers this cycle; buffer pops
//  proto_err    out  1   sticky protocol-error flag
// BEHAVIOUR
//  - Output k state: IDLE or LOCKED(owner[2:0]); rr_ptr_k[2:0] marks highest-priority input.
//  - Reset values: all outputs 0; all states IDLE; rr_ptr = 0; proto_err = 0.
//  - sel/out_valid/in_grant are combinational from registered state plus current inputs (0-cycle latency).
//    They are forced to 0 while rst_n is low.
//  - Flit transfers when sel_k[i]=1; in_grant[i] = OR over k of sel_k[i].
//  - IDLE arbitration for output k:
//    - Candidates: req_valid[i] & req_head[i] & dst_i==k.
//    - Winner: first candidate at or after rr_ptr_k, wrapping 4->0.
//    - Grant only if out_ready[k]; otherwise sel_k=0 and nothing changes.
//  - On a head grant to input i:
//    - rr_ptr_k <= (i+1) mod 5.
//    - If req_tail[i]=0, state <= LOCKED(i). A single-flit packet stays IDLE.
//  - LOCKED(o):
//    - sel_k = onehot(o) iff req_valid[o] & out_ready[k]; else 0 and stay locked.
//    - Other inputs never win k during the lock; owner bubbles hold the lock.
//    - Tail transfer from o -> IDLE next cycle; a new head can win in that next cycle.
//  - Independent outputs arbitrate in parallel.
//    - An input requests exactly one output, so in_grant cannot double-count.
//    - All 5 outputs may grant in the same cycle.
//  - U-turn (dst == own input index) is legal and handled like any other request.
//  - proto_err <= 1 (sticky until reset) and the request is ignored when:
//    - a head flit has dst >= 5; or
//    - a valid non-head flit arrives from input i while i owns no output.
//  - Head flit from the current owner o while LOCKED (missing tail): transfers as body, sets proto_err.
//  - Reset asserted mid-packet: locks are dropped immediately; upstream buffers are flushed by the same reset.
// STRUCTURE
//  - Shared package / parameters.v:
//    - P_NUM_PORTS, port-ID constants (PORT_LOCAL..PORT_W), state encoding (ST_IDLE=0, ST_LOCKED=1).
//    - Helper function onehot5(idx).
//  - Sub-module m_rr_arbiter: 5-bit request in, 3-bit pointer in, one-hot grant plus any-grant out, combinational.
//  - Top instantiates m_rr_arbiter 5x in a generate loop; each instance gets its own lock/owner/pointer registers.
// TESTING
//  1 Reset: rst_n=0 with req_valid=5'h1F -> all sel/in_grant/out_valid=0; after release, rr_ptr=0.
//  2 Contention: inputs 1,2,3 send single-flit heads to port 2, out_ready=1F.
//    -> Grants go to inputs 1,2,3 on consecutive cycles; rr_ptr_2 ends at 4.
//  3 Wormhole lock: input 0 sends 4-flit packet to port 3 while input 4 holds a head for port 3.
//    -> sel_3=00001 for 4 flits; sel_3=10000 on the cycle after the tail.
//  4 Backpressure and bubble: during a lock, drop out_ready[3] for 2 cycles, then req_valid[0] for 1 cycle.
//    -> sel_3=0 on those 3 cycles, lock held, no flit lost.
//  5 Parallel: 5 inputs send heads to 5 distinct outputs in one cycle -> in_grant=1F, each sel_k one-hot correct.
//  6 Errors: head with dst=6, and a body flit from an unlocked input.
//    -> proto_err=1 next cycle, sticky; no grant issued.

Source files
------------

// File: rtl/m_switch_allocator_pkg.sv
// Shared definitions for the 5-port wormhole switch allocator.
// Holds the router radix, port-ID constants, the per-output state encoding,
// and the small index helpers used by the allocator and its arbiters.
package m_switch_allocator_pkg;

  localparam int P_NUM_PORTS = 5;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_N     = 3'd1;
  localparam logic [2:0] PORT_E     = 3'd2;
  localparam logic [2:0] PORT_S     = 3'd3;
  localparam logic [2:0] PORT_W     = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // One-hot select for port index idx (0..4).
  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    onehot5 = 5'b00001 << idx;
  endfunction

  // Index of the set bit in a one-hot 5-bit vector (0 when empty).
  function automatic logic [2:0] enc5(input logic [4:0] oh);
    enc5 = PORT_LOCAL;
    for (int i = 0; i < P_NUM_PORTS; i++) begin
      if (oh[i]) enc5 = 3'(i);
    end
  endfunction

  // Increment a port index with wrap 4 -> 0.
  function automatic logic [2:0] inc_mod5(input logic [2:0] v);
    inc_mod5 = (v >= PORT_W) ? PORT_LOCAL : v + 3'd1;
  endfunction

endpackage

// File: rtl/m_switch_allocator_arb.sv
// Combinational 5-input round-robin arbiter.
// Ports:
//   req_i  in  5  request vector
//   ptr_i  in  3  highest-priority input index (values above 4 act as 0)
//   gnt_o  out 5  one-hot grant: first requester at or after ptr_i, wrapping 4->0
//   any_o  out 1  at least one request was granted
module m_rr_arbiter (
  input  logic [4:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [4:0] gnt_o,
  output logic       any_o
);
  import m_switch_allocator_pkg::*;

  logic [2:0] idx;
  logic       found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = (ptr_i > PORT_W) ? PORT_LOCAL : ptr_i;
    for (int off = 0; off < P_NUM_PORTS; off++) begin
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = inc_mod5(idx);
    end
  end

  assign any_o = |gnt_o;

endmodule

// File: rtl/m_switch_allocator.sv
// Wormhole switch allocator for the 5-port router, directly upstream of the
// crossbar. Each output picks one input by round-robin and holds it for the
// whole packet.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/head/tail per-input head-of-buffer flit flags (5 bits each)
//   req_dst             per-input routed output port, 3 bits per input
//   out_ready           per-output credit available
//   sel_0..sel_4        one-hot crossbar input select per output (0 = idle)
//   out_valid           per-output transfer this cycle
//   in_grant            per-input transfer this cycle (buffer pop)
//   proto_err           sticky protocol-error flag
module m_switch_allocator #(
  parameter int P_NUM_PORTS = 5,
  parameter int P_DST_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [P_NUM_PORTS-1:0]           req_valid,
  input  logic [P_NUM_PORTS-1:0]           req_head,
  input  logic [P_NUM_PORTS-1:0]           req_tail,
  input  logic [P_NUM_PORTS*P_DST_WIDTH-1:0] req_dst,
  input  logic [P_NUM_PORTS-1:0]           out_ready,
  output logic [P_NUM_PORTS-1:0]           sel_0,
  output logic [P_NUM_PORTS-1:0]           sel_1,
  output logic [P_NUM_PORTS-1:0]           sel_2,
  output logic [P_NUM_PORTS-1:0]           sel_3,
  output logic [P_NUM_PORTS-1:0]           sel_4,
  output logic [P_NUM_PORTS-1:0]           out_valid,
  output logic [P_NUM_PORTS-1:0]           in_grant,
  output logic                             proto_err
);
  import m_switch_allocator_pkg::*;

  localparam logic [P_DST_WIDTH-1:0] NUM_PORTS_D = P_DST_WIDTH'(P_NUM_PORTS);

  logic [P_DST_WIDTH-1:0] dst_w    [P_NUM_PORTS];
  logic [P_NUM_PORTS-1:0] sel_w    [P_NUM_PORTS];
  logic [2:0]             owner_w  [P_NUM_PORTS];
  logic [P_NUM_PORTS-1:0] locked_w;
  logic [P_NUM_PORTS-1:0] owns_w;
  logic [P_NUM_PORTS-1:0] err_w;
  logic                   proto_err_q;

  for (genvar i = 0; i < P_NUM_PORTS; i++) begin : g_dst
    assign dst_w[i] = req_dst[i*P_DST_WIDTH +: P_DST_WIDTH];
  end

  // An input that owns an output is mid-packet: its flits only go to that
  // output, so it must not compete for any other output.
  always_comb begin
    owns_w = '0;
    for (int k = 0; k < P_NUM_PORTS; k++) begin
      if (locked_w[k]) owns_w[owner_w[k]] = 1'b1;
    end
  end

  // Protocol errors: bad head destination, head from an owner (missing tail),
  // or a body/tail flit from an input that owns nothing.
  always_comb begin
    err_w = '0;
    for (int i = 0; i < P_NUM_PORTS; i++) begin
      if (req_valid[i]) begin
        if (req_head[i]) err_w[i] = owns_w[i] | (dst_w[i] >= NUM_PORTS_D);
        else             err_w[i] = ~owns_w[i];
      end
    end
  end

  for (genvar k = 0; k < P_NUM_PORTS; k++) begin : g_out
    state_e                 state_q, state_d;
    logic [2:0]             owner_q, owner_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [P_NUM_PORTS-1:0] cand;
    logic [P_NUM_PORTS-1:0] gnt;
    logic                   any;
    logic [P_NUM_PORTS-1:0] sel;
    logic [2:0]             win;

    always_comb begin
      cand = '0;
      for (int i = 0; i < P_NUM_PORTS; i++) begin
        cand[i] = req_valid[i] & req_head[i] & ~owns_w[i] &
                  (dst_w[i] == P_DST_WIDTH'(k));
      end
    end

    m_rr_arbiter u_arb (
      .req_i (cand),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .any_o (any)
    );

    assign win = enc5(gnt);

    always_comb begin
      sel     = '0;
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (state_q == ST_LOCKED) begin
        // Owner bubbles or missing credit simply hold the lock.
        if (req_valid[owner_q] && out_ready[k]) begin
          sel = onehot5(owner_q);
          if (req_tail[owner_q]) state_d = ST_IDLE;
        end
      end else if (any && out_ready[k]) begin
        sel   = gnt;
        ptr_d = inc_mod5(win);
        // Single-flit packets (head & tail) leave the output idle.
        if (!req_tail[win]) begin
          state_d = ST_LOCKED;
          owner_d = win;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        owner_q <= PORT_LOCAL;
        ptr_q   <= PORT_LOCAL;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    // Selects are forced idle while reset is held, independent of the clock.
    assign sel_w[k]    = rst_n ? sel : '0;
    assign locked_w[k] = (state_q == ST_LOCKED);
    assign owner_w[k]  = owner_q;
    assign out_valid[k] = |sel_w[k];
  end

  always_comb begin
    in_grant = '0;
    for (int k = 0; k < P_NUM_PORTS; k++) begin
      in_grant = in_grant | sel_w[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      proto_err_q <= 1'b0;
    else if (|err_w) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
  assign sel_0 = sel_w[0];
  assign sel_1 = sel_w[1];
  assign sel_2 = sel_w[2];
  assign sel_3 = sel_w[3];
  assign sel_4 = sel_w[4];

endmodule

// File: tb/tb_m_switch_allocator.sv
// Directed bench for the 5-port wormhole switch allocator.
module tb_m_switch_allocator;
  import m_switch_allocator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid, req_head, req_tail, out_ready;
  logic [14:0] req_dst;
  logic [4:0]  sel_0, sel_1, sel_2, sel_3, sel_4;
  logic [4:0]  out_valid, in_grant;
  logic        proto_err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  m_switch_allocator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_head  (req_head),
    .req_tail  (req_tail),
    .req_dst   (req_dst),
    .out_ready (out_ready),
    .sel_0     (sel_0),
    .sel_1     (sel_1),
    .sel_2     (sel_2),
    .sel_3     (sel_3),
    .sel_4     (sel_4),
    .out_valid (out_valid),
    .in_grant  (in_grant),
    .proto_err (proto_err)
  );

  function automatic logic [14:0] dp(input logic [2:0] d0, d1, d2, d3, d4);
    dp = {d4, d3, d2, d1, d0};
  endfunction

  // Apply inputs just after the falling edge, then let them settle.
  task automatic drv(input logic [4:0] v, h, t, input logic [14:0] d, input logic [4:0] r);
    @(negedge clk);
    req_valid = v;
    req_head  = h;
    req_tail  = t;
    req_dst   = d;
    out_ready = r;
    #1;
  endtask

  task automatic idle();
    drv(5'h00, 5'h00, 5'h00, 15'h0, 5'h1F);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] allsel();
    allsel = {7'd0, sel_4, sel_3, sel_2, sel_1, sel_0};
  endfunction

  logic [14:0] d;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_head = '0; req_tail = '0; req_dst = '0; out_ready = '0;

    // Reset held with every input requesting: everything must stay idle.
    drv(5'h1F, 5'h1F, 5'h1F, dp(PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL), 5'h1F);
    chk("rst_sel", allsel(), 32'h0);
    chk("rst_grant", {27'd0, in_grant}, 32'h0);
    chk("rst_ovalid", {27'd0, out_valid}, 32'h0);
    chk("rst_err", {31'd0, proto_err}, 32'h0);
    req_valid = '0;
    rst_n = 1'b1;

    // Pointer starts at 0: input 0 wins port 0 among all five.
    drv(5'h1F, 5'h1F, 5'h1F, dp(PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL), 5'h1F);
    chk("ptr0_sel0", {27'd0, sel_0}, 32'h01);
    chk("ptr0_grant", {27'd0, in_grant}, 32'h01);
    chk("ptr0_ovalid", {27'd0, out_valid}, 32'h01);
    idle();

    // Contention on port E from inputs 1,2,3 (single-flit packets).
    d = dp(PORT_LOCAL, PORT_E, PORT_E, PORT_E, PORT_LOCAL);
    drv(5'b01110, 5'b01110, 5'b01110, d, 5'h1F);
    chk("cont_c1", {27'd0, sel_2}, 32'h02);
    chk("cont_c1_grant", {27'd0, in_grant}, 32'h02);
    drv(5'b01100, 5'b01100, 5'b01100, d, 5'h1F);
    chk("cont_c2", {27'd0, sel_2}, 32'h04);
    drv(5'b01000, 5'b01000, 5'b01000, d, 5'h1F);
    chk("cont_c3", {27'd0, sel_2}, 32'h08);
    // Pointer now 4: input 4 beats input 0.
    d = dp(PORT_E, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_E);
    drv(5'b10001, 5'b10001, 5'b10001, d, 5'h1F);
    chk("cont_ptr4", {27'd0, sel_2}, 32'h10);
    chk("cont_ptr4_grant", {27'd0, in_grant}, 32'h10);
    idle();

    // Wormhole lock on port S by input 0 while input 4 waits with a head.
    d = dp(PORT_S, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_S);
    drv(5'b10001, 5'b10001, 5'b10000, d, 5'h1F);
    chk("lock_head", {27'd0, sel_3}, 32'h01);
    chk("lock_head_grant", {27'd0, in_grant}, 32'h01);
    drv(5'b10001, 5'b10000, 5'b10000, d, 5'h1F);
    chk("lock_body1", {27'd0, sel_3}, 32'h01);
    // Credit lost for two cycles.
    drv(5'b10001, 5'b10000, 5'b10000, d, 5'b10111);
    chk("bp_c1_sel", {27'd0, sel_3}, 32'h00);
    chk("bp_c1_grant", {27'd0, in_grant}, 32'h00);
    drv(5'b10001, 5'b10000, 5'b10000, d, 5'b10111);
    chk("bp_c2_sel", {27'd0, sel_3}, 32'h00);
    chk("bp_c2_ovalid", {27'd0, out_valid}, 32'h00);
    // Owner bubble: input 4 must not steal the locked output.
    drv(5'b10000, 5'b10000, 5'b10000, d, 5'h1F);
    chk("bubble_sel", {27'd0, sel_3}, 32'h00);
    chk("bubble_grant", {27'd0, in_grant}, 32'h00);
    drv(5'b10001, 5'b10000, 5'b10000, d, 5'h1F);
    chk("lock_body2", {27'd0, sel_3}, 32'h01);
    drv(5'b10001, 5'b10000, 5'b10001, d, 5'h1F);
    chk("lock_tail", {27'd0, sel_3}, 32'h01);
    drv(5'b10000, 5'b10000, 5'b10000, d, 5'h1F);
    chk("after_tail", {27'd0, sel_3}, 32'h10);
    chk("after_tail_grant", {27'd0, in_grant}, 32'h10);
    chk("lock_no_err", {31'd0, proto_err}, 32'h0);
    idle();

    // All five outputs granted in parallel: input i -> port (i+1) mod 5.
    d = dp(PORT_N, PORT_E, PORT_S, PORT_W, PORT_LOCAL);
    drv(5'h1F, 5'h1F, 5'h1F, d, 5'h1F);
    chk("par_grant", {27'd0, in_grant}, 32'h1F);
    chk("par_ovalid", {27'd0, out_valid}, 32'h1F);
    chk("par_sel", allsel(), {7'd0, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000});
    chk("par_no_err", {31'd0, proto_err}, 32'h0);
    idle();

    // Head with out-of-range destination.
    drv(5'b00100, 5'b00100, 5'b00100, dp(PORT_LOCAL, PORT_LOCAL, 3'd6, PORT_LOCAL, PORT_LOCAL), 5'h1F);
    chk("baddst_grant", {27'd0, in_grant}, 32'h00);
    chk("baddst_ovalid", {27'd0, out_valid}, 32'h00);
    chk("baddst_err_now", {31'd0, proto_err}, 32'h0);
    idle();
    chk("baddst_err_next", {31'd0, proto_err}, 32'h1);
    idle();
    chk("baddst_sticky", {31'd0, proto_err}, 32'h1);

    // Reset clears the flag; then a body flit from an unlocked input.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", {31'd0, proto_err}, 32'h0);
    rst_n = 1'b1;
    drv(5'b00010, 5'b00000, 5'b00000, dp(PORT_LOCAL, PORT_S, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL), 5'h1F);
    chk("orphan_grant", {27'd0, in_grant}, 32'h00);
    chk("orphan_ovalid", {27'd0, out_valid}, 32'h00);
    idle();
    chk("orphan_err", {31'd0, proto_err}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
